// File: rtl/householder_sequencer.sv
// householder_sequencer
//   Controller for the 2x2 Householder transforming-matrix datapath
//   (H = I - 2*w*w^T, Q8.8 results). It takes one vector (w1, w2) per
//   transfer, holds it on the datapath inputs, and enables the datapath for
//   exactly LAT clock edges. It then captures the four H entries and offers
//   them downstream.
//
// Parameters
//   LAT                    datapath pipeline depth in enabled edges (1..15)
// Ports
//   I_sys_clk              system clock, rising edge
//   I_sys_rstn             asynchronous active-low reset
//   I_abort                synchronous abort, forces IDLE
//   I_start_valid          upstream offers a vector
//   O_start_ready          vector can be accepted (IDLE and no abort)
//   I_w1, I_w2             vector components, sampled on accept
//   O_w_1_1_final,
//   O_w_2_1_final          registered vector driven to the datapath
//   O_enable_transforming  datapath clock-enable
//   I_H1_h11..I_H1_h22     datapath outputs
//   O_h11..O_h22           captured result (Q8.8)
//   O_done_valid           result valid
//   I_done_ready           downstream takes the result
//   O_busy                 state is not IDLE
//   O_count                completed transfers, wraps at 16 bits
module householder_sequencer #(
  parameter int unsigned LAT = 2
) (
  input  logic        I_sys_clk,
  input  logic        I_sys_rstn,
  input  logic        I_abort,
  input  logic        I_start_valid,
  output logic        O_start_ready,
  input  logic [31:0] I_w1,
  input  logic [31:0] I_w2,
  output logic [31:0] O_w_1_1_final,
  output logic [31:0] O_w_2_1_final,
  output logic        O_enable_transforming,
  input  logic [15:0] I_H1_h11,
  input  logic [15:0] I_H1_h12,
  input  logic [15:0] I_H1_h21,
  input  logic [15:0] I_H1_h22,
  output logic [15:0] O_h11,
  output logic [15:0] O_h12,
  output logic [15:0] O_h21,
  output logic [15:0] O_h22,
  output logic        O_done_valid,
  input  logic        I_done_ready,
  output logic        O_busy,
  output logic [15:0] O_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // RUN ends on the edge where the counter shows LAT-1, giving LAT RUN cycles.
  localparam logic [3:0] LastCnt = 4'(LAT - 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        en_q;
  logic        dv_q;
  logic [31:0] w1_q;
  logic [31:0] w2_q;
  logic [15:0] h11_q;
  logic [15:0] h12_q;
  logic [15:0] h21_q;
  logic [15:0] h22_q;
  logic [15:0] count_q;
  logic        accept;

  assign O_start_ready = (state_q == IDLE) && !I_abort;
  assign accept        = I_start_valid && O_start_ready;

  always_ff @(posedge I_sys_clk or negedge I_sys_rstn) begin
    if (!I_sys_rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      dv_q    <= 1'b0;
      w1_q    <= '0;
      w2_q    <= '0;
      h11_q   <= '0;
      h12_q   <= '0;
      h21_q   <= '0;
      h22_q   <= '0;
      count_q <= '0;
    end else if (I_abort) begin
      // Vector and result registers are deliberately left untouched.
      state_q <= IDLE;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      dv_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            w1_q    <= I_w1;
            w2_q    <= I_w2;
            cnt_q   <= '0;
            en_q    <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == LastCnt) begin
            // Drop the enable together with leaving RUN so the datapath
            // stays frozen while its outputs are captured.
            en_q    <= 1'b0;
            state_q <= CAPTURE;
          end
        end
        CAPTURE: begin
          h11_q   <= I_H1_h11;
          h12_q   <= I_H1_h12;
          h21_q   <= I_H1_h21;
          h22_q   <= I_H1_h22;
          dv_q    <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          if (I_done_ready) begin
            dv_q    <= 1'b0;
            count_q <= count_q + 16'd1;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          en_q    <= 1'b0;
          dv_q    <= 1'b0;
        end
      endcase
    end
  end

  assign O_busy                = (state_q != IDLE);
  assign O_enable_transforming = en_q;
  assign O_done_valid          = dv_q;
  assign O_w_1_1_final         = w1_q;
  assign O_w_2_1_final         = w2_q;
  assign O_h11                 = h11_q;
  assign O_h12                 = h12_q;
  assign O_h21                 = h21_q;
  assign O_h22                 = h22_q;
  assign O_count               = count_q;

endmodule

// File: tb/tb_householder_sequencer.sv
// Self-checking bench for householder_sequencer. The main instance uses
// LAT=2 with an enable-gated two-stage datapath model; two extra instances
// with LAT=1 and LAT=15 use a combinational datapath model.
module tb_householder_sequencer;

  logic        clk;
  logic        rstn;
  logic        abort_i;
  logic        sv;
  logic        sv_a;
  logic        sv_b;
  logic        dr;
  logic [31:0] w1;
  logic [31:0] w2;

  // main instance (LAT=2)
  logic        sr, en, dv, busy;
  logic [31:0] w1o, w2o;
  logic [15:0] h11, h12, h21, h22, cnt;
  logic [15:0] m11, m12, m21, m22;
  logic [15:0] p11, p12, p22;

  // LAT=1 instance
  logic        sr_a, en_a, dv_a, busy_a;
  logic [31:0] w1o_a, w2o_a;
  logic [15:0] h11_a, h12_a, h21_a, h22_a, cnt_a;
  logic [15:0] d11_a, d12_a, d22_a;

  // LAT=15 instance
  logic        sr_b, en_b, dv_b, busy_b;
  logic [31:0] w1o_b, w2o_b;
  logic [15:0] h11_b, h12_b, h21_b, h22_b, cnt_b;
  logic [15:0] d11_b, d12_b, d22_b;

  int tests = 0;
  int fails = 0;

  // Q8.8 x Q8.8 -> Q8.8
  function automatic logic [15:0] qmul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] ea;
    logic signed [63:0] eb;
    logic signed [63:0] p;
    ea = $signed(a);
    eb = $signed(b);
    p  = ea * eb;
    return p[23:8];
  endfunction

  function automatic logic [15:0] hdiag(input logic [15:0] p);
    return 16'h0100 - {p[14:0], 1'b0};
  endfunction

  function automatic logic [15:0] hoff(input logic [15:0] p);
    return 16'h0000 - {p[14:0], 1'b0};
  endfunction

  // Datapath model for LAT=2: products stage, then add/sub stage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p11 <= '0; p12 <= '0; p22 <= '0;
      m11 <= '0; m12 <= '0; m21 <= '0; m22 <= '0;
    end else if (en) begin
      p11 <= qmul(w1o, w1o);
      p12 <= qmul(w1o, w2o);
      p22 <= qmul(w2o, w2o);
      m11 <= hdiag(p11);
      m12 <= hoff(p12);
      m21 <= hoff(p12);
      m22 <= hdiag(p22);
    end
  end

  assign d11_a = hdiag(qmul(w1o_a, w1o_a));
  assign d12_a = hoff(qmul(w1o_a, w2o_a));
  assign d22_a = hdiag(qmul(w2o_a, w2o_a));
  assign d11_b = hdiag(qmul(w1o_b, w1o_b));
  assign d12_b = hoff(qmul(w1o_b, w2o_b));
  assign d22_b = hdiag(qmul(w2o_b, w2o_b));

  householder_sequencer #(.LAT(2)) dut (
    .I_sys_clk(clk), .I_sys_rstn(rstn), .I_abort(abort_i),
    .I_start_valid(sv), .O_start_ready(sr), .I_w1(w1), .I_w2(w2),
    .O_w_1_1_final(w1o), .O_w_2_1_final(w2o), .O_enable_transforming(en),
    .I_H1_h11(m11), .I_H1_h12(m12), .I_H1_h21(m21), .I_H1_h22(m22),
    .O_h11(h11), .O_h12(h12), .O_h21(h21), .O_h22(h22),
    .O_done_valid(dv), .I_done_ready(dr), .O_busy(busy), .O_count(cnt)
  );

  householder_sequencer #(.LAT(1)) dut_a (
    .I_sys_clk(clk), .I_sys_rstn(rstn), .I_abort(abort_i),
    .I_start_valid(sv_a), .O_start_ready(sr_a), .I_w1(w1), .I_w2(w2),
    .O_w_1_1_final(w1o_a), .O_w_2_1_final(w2o_a), .O_enable_transforming(en_a),
    .I_H1_h11(d11_a), .I_H1_h12(d12_a), .I_H1_h21(d12_a), .I_H1_h22(d22_a),
    .O_h11(h11_a), .O_h12(h12_a), .O_h21(h21_a), .O_h22(h22_a),
    .O_done_valid(dv_a), .I_done_ready(dr), .O_busy(busy_a), .O_count(cnt_a)
  );

  householder_sequencer #(.LAT(15)) dut_b (
    .I_sys_clk(clk), .I_sys_rstn(rstn), .I_abort(abort_i),
    .I_start_valid(sv_b), .O_start_ready(sr_b), .I_w1(w1), .I_w2(w2),
    .O_w_1_1_final(w1o_b), .O_w_2_1_final(w2o_b), .O_enable_transforming(en_b),
    .I_H1_h11(d11_b), .I_H1_h12(d12_b), .I_H1_h21(d12_b), .I_H1_h22(d22_b),
    .O_h11(h11_b), .O_h12(h12_b), .O_h21(h21_b), .O_h22(h22_b),
    .O_done_valid(dv_b), .I_done_ready(dr), .O_busy(busy_b), .O_count(cnt_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One complete transfer on the main instance. lat counts edges after the
  // accept edge until O_done_valid is seen; en_cnt counts enabled cycles.
  task automatic xfer(input logic [31:0] a, input logic [31:0] b, input bit rdy_early,
                      output int en_cnt, output int lat);
    @(negedge clk);
    w1 = a; w2 = b; sv = 1'b1; dr = rdy_early;
    @(negedge clk);
    sv = 1'b0;
    lat = 0;
    en_cnt = en ? 1 : 0;
    while (!dv && lat < 40) begin
      @(negedge clk);
      lat++;
      if (en) en_cnt++;
    end
    dr = 1'b1;
    @(negedge clk);
    dr = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b0; abort_i = 1'b0; sv = 1'b0; sv_a = 1'b0; sv_b = 1'b0;
    dr = 1'b0; w1 = '0; w2 = '0;
    #3;
    tests++;
    if ({sr, busy, en, dv} !== 4'b1000) begin
      fails++; $display("FAIL reset_flags: got sr/busy/en/dv=%b want 1000", {sr, busy, en, dv});
    end
    tests++;
    if ({w1o, w2o, h11, h12, h21, h22, cnt} !== '0) begin
      fails++; $display("FAIL reset_regs: got w=%h/%h h=%h %h %h %h cnt=%h want all 0",
                        w1o, w2o, h11, h12, h21, h22, cnt);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    tests++;
    if ({sr, busy, en, dv} !== 4'b1000) begin
      fails++; $display("FAIL post_reset_idle: got sr/busy/en/dv=%b want 1000", {sr, busy, en, dv});
    end
  endtask

  task automatic test_zero_vector;
    int e, l;
    xfer(32'h0, 32'h0, 1'b1, e, l);
    tests++;
    if (l !== 3) begin fails++; $display("FAIL zero_latency: got %0d want 3", l); end
    tests++;
    if (e !== 2) begin fails++; $display("FAIL zero_enable_width: got %0d want 2", e); end
    tests++;
    if ({h11, h12, h21, h22} !== {16'h0100, 16'h0000, 16'h0000, 16'h0100}) begin
      fails++; $display("FAIL zero_h: got %h %h %h %h want 0100 0000 0000 0100", h11, h12, h21, h22);
    end
    tests++;
    if (cnt !== 16'd1) begin fails++; $display("FAIL zero_count: got %0d want 1", cnt); end
    tests++;
    if ({busy, dv} !== 2'b00) begin fails++; $display("FAIL zero_after_hs: got busy/dv=%b want 00", {busy, dv}); end
  endtask

  task automatic test_unit_vector;
    int e, l;
    xfer(32'h0000_0100, 32'h0, 1'b0, e, l);
    tests++;
    if ({h11, h12, h21, h22} !== {16'hFF00, 16'h0000, 16'h0000, 16'h0100}) begin
      fails++; $display("FAIL unit_h: got %h %h %h %h want ff00 0000 0000 0100", h11, h12, h21, h22);
    end
    tests++;
    if (w1o !== 32'h0000_0100) begin fails++; $display("FAIL unit_w1: got %h want 00000100", w1o); end
    tests++;
    if (cnt !== 16'd2) begin fails++; $display("FAIL unit_count: got %0d want 2", cnt); end
  endtask

  task automatic test_backpressure;
    int n, bad;
    @(negedge clk);
    w1 = 32'h80; w2 = 32'h80; sv = 1'b1; dr = 1'b0;
    @(negedge clk);
    sv = 1'b0;
    n = 0;
    while (!dv && n < 40) begin @(negedge clk); n++; end
    tests++;
    if (dv !== 1'b1) begin fails++; $display("FAIL bp_valid_timeout: got dv=%b want 1", dv); end
    tests++;
    if ({h11, h12, h21, h22} !== {16'h0080, 16'hFF80, 16'hFF80, 16'h0080}) begin
      fails++; $display("FAIL bp_h: got %h %h %h %h want 0080 ff80 ff80 0080", h11, h12, h21, h22);
    end
    // Offer a new vector during the stall; it must wait.
    w1 = 32'h0; w2 = 32'h100; sv = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dv !== 1'b1 || sr !== 1'b0 || w1o !== 32'h80 ||
          {h11, h12, h21, h22} !== {16'h0080, 16'hFF80, 16'hFF80, 16'h0080}) bad++;
    end
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL bp_stall_stable: got %0d unstable cycles want 0", bad); end
    dr = 1'b1;
    @(negedge clk);
    dr = 1'b0;
    tests++;
    if ({busy, dv, sr} !== 3'b001 || cnt !== 16'd3) begin
      fails++; $display("FAIL bp_handshake: got busy/dv/sr=%b cnt=%0d want 001 cnt=3", {busy, dv, sr}, cnt);
    end
    @(negedge clk);
    sv = 1'b0;
    tests++;
    if (busy !== 1'b1 || w1o !== 32'h0 || w2o !== 32'h100) begin
      fails++; $display("FAIL bp_next_accept: got busy=%b w=%h/%h want 1 00000000/00000100", busy, w1o, w2o);
    end
    n = 0;
    while (!dv && n < 40) begin @(negedge clk); n++; end
    tests++;
    if ({h11, h12, h21, h22} !== {16'h0100, 16'h0000, 16'h0000, 16'hFF00}) begin
      fails++; $display("FAIL bp_second_h: got %h %h %h %h want 0100 0000 0000 ff00", h11, h12, h21, h22);
    end
    dr = 1'b1;
    @(negedge clk);
    dr = 1'b0;
    tests++;
    if (cnt !== 16'd4) begin fails++; $display("FAIL bp_count: got %0d want 4", cnt); end
  endtask

  task automatic test_abort;
    int rose;
    @(negedge clk);
    w1 = 32'h100; w2 = 32'h0; sv = 1'b1;
    @(negedge clk);
    sv = 1'b0;                 // first RUN cycle
    @(negedge clk);
    abort_i = 1'b1;            // second RUN cycle
    @(negedge clk);
    tests++;
    if ({busy, en, dv, sr} !== 4'b0000) begin
      fails++; $display("FAIL abort_idle: got busy/en/dv/sr=%b want 0000", {busy, en, dv, sr});
    end
    sv = 1'b1;                 // offered while abort is still high
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL abort_accept_suppressed: got busy=%b want 0", busy); end
    abort_i = 1'b0; sv = 1'b0;
    rose = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (dv) rose++;
    end
    tests++;
    if (rose !== 0) begin fails++; $display("FAIL abort_no_valid: got %0d valid cycles want 0", rose); end
    tests++;
    if (cnt !== 16'd4) begin fails++; $display("FAIL abort_count: got %0d want 4", cnt); end
    tests++;
    if ({h11, h12, h21, h22} !== {16'h0100, 16'h0000, 16'h0000, 16'hFF00}) begin
      fails++; $display("FAIL abort_h_retained: got %h %h %h %h want 0100 0000 0000 ff00", h11, h12, h21, h22);
    end
  endtask

  task automatic test_async_reset;
    int e, l, n;
    xfer(32'h80, 32'h80, 1'b0, e, l);
    @(negedge clk);
    w1 = 32'h100; w2 = 32'h0; sv = 1'b1; dr = 1'b0;
    @(negedge clk);
    sv = 1'b0;
    n = 0;
    while (!dv && n < 40) begin @(negedge clk); n++; end
    tests++;
    if (dv !== 1'b1 || cnt !== 16'd5) begin
      fails++; $display("FAIL rst_precond: got dv=%b cnt=%0d want 1 cnt=5", dv, cnt);
    end
    #2 rstn = 1'b0;
    #1;
    tests++;
    if ({sr, busy, en, dv} !== 4'b1000) begin
      fails++; $display("FAIL rst_async_flags: got sr/busy/en/dv=%b want 1000", {sr, busy, en, dv});
    end
    tests++;
    if ({w1o, w2o, h11, h12, h21, h22, cnt} !== '0) begin
      fails++; $display("FAIL rst_async_regs: got w=%h/%h h=%h %h %h %h cnt=%h want all 0",
                        w1o, w2o, h11, h12, h21, h22, cnt);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_back_to_back;
    int rise[2];
    int nr;
    logic prev;
    @(negedge clk);
    w1 = 32'h0; w2 = 32'h100; sv = 1'b1; dr = 1'b1;
    prev = busy;
    nr = 0;
    rise[0] = 0; rise[1] = 0;
    for (int i = 0; i < 30 && nr < 2; i++) begin
      @(negedge clk);
      if (busy && !prev) begin rise[nr] = i; nr++; end
      prev = busy;
    end
    sv = 1'b0;
    repeat (8) @(negedge clk);
    dr = 1'b0;
    tests++;
    if (nr !== 2 || rise[1] - rise[0] !== 5) begin
      fails++; $display("FAIL b2b_interval: got %0d accepts interval %0d want 2 interval 5", nr, rise[1] - rise[0]);
    end
    tests++;
    if (cnt !== 16'd2) begin fails++; $display("FAIL b2b_count: got %0d want 2", cnt); end
    tests++;
    if ({h11, h12, h21, h22} !== {16'h0100, 16'h0000, 16'h0000, 16'hFF00}) begin
      fails++; $display("FAIL b2b_h: got %h %h %h %h want 0100 0000 0000 ff00", h11, h12, h21, h22);
    end
  endtask

  task automatic test_wrap;
    int e, l;
    @(negedge clk);
    dut.count_q = 16'hFFFF;    // preload instead of 65535 real transfers
    @(negedge clk);
    tests++;
    if (cnt !== 16'hFFFF) begin fails++; $display("FAIL wrap_preload: got %h want ffff", cnt); end
    xfer(32'h0, 32'h0, 1'b1, e, l);
    tests++;
    if (cnt !== 16'h0000) begin fails++; $display("FAIL wrap_count: got %h want 0000", cnt); end
    tests++;
    if (l !== 3) begin fails++; $display("FAIL wrap_latency: got %0d want 3", l); end
  endtask

  task automatic test_lat_sweep;
    for (int k = 0; k < 2; k++) begin
      int exp_lat, ec, lat;
      logic [15:0] hk11, hk22, ck;
      exp_lat = (k == 0) ? 1 : 15;
      @(negedge clk);
      w1 = 32'h100; w2 = 32'h0; dr = 1'b1;
      if (k == 0) sv_a = 1'b1; else sv_b = 1'b1;
      @(negedge clk);
      sv_a = 1'b0; sv_b = 1'b0;
      lat = 0;
      ec = ((k == 0) ? en_a : en_b) ? 1 : 0;
      while (!((k == 0) ? dv_a : dv_b) && lat < 60) begin
        @(negedge clk);
        lat++;
        if ((k == 0) ? en_a : en_b) ec++;
      end
      hk11 = (k == 0) ? h11_a : h11_b;
      hk22 = (k == 0) ? h22_a : h22_b;
      @(negedge clk);
      ck = (k == 0) ? cnt_a : cnt_b;
      dr = 1'b0;
      tests++;
      if (ec !== exp_lat) begin fails++; $display("FAIL sweep%0d_enable_width: got %0d want %0d", exp_lat, ec, exp_lat); end
      tests++;
      if (lat !== exp_lat + 1) begin fails++; $display("FAIL sweep%0d_latency: got %0d want %0d", exp_lat, lat, exp_lat + 1); end
      tests++;
      if (hk11 !== 16'hFF00 || hk22 !== 16'h0100) begin
        fails++; $display("FAIL sweep%0d_h: got %h %h want ff00 0100", exp_lat, hk11, hk22);
      end
      tests++;
      if (ck !== 16'd1) begin fails++; $display("FAIL sweep%0d_count: got %0d want 1", exp_lat, ck); end
    end
  endtask

  initial begin
    test_reset();
    test_zero_vector();
    test_unit_vector();
    test_backpressure();
    test_abort();
    test_async_reset();
    test_back_to_back();
    test_wrap();
    test_lat_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
